// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller: register-number type,
// FSM state encoding and default mul/div latency.
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int MD_LAT_DEF     = 8;
  localparam int CNT_W_DEF      = 8;

  typedef logic [REG_ADDR_W_DEF-1:0] reg_addr_bus_t;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle: ID/EX hazard inputs and the stall/flush outputs.
// master = pipeline (drives ID/EX info), slave = hazard controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs_num;
  logic [REG_ADDR_W-1:0] id_rt_num;
  logic                  id_uses_rs;
  logic                  id_uses_rt;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_reg_addr;
  logic                  ex_md_op;
  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  id_ex_stall;
  logic                  id_ex_flush;
  logic                  ex_mem_bubble;
  logic                  md_busy;

  modport master (
    output id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
           ex_mem_read, ex_reg_addr, ex_md_op,
    input  pc_stall, if_id_stall, id_ex_stall, id_ex_flush,
           ex_mem_bubble, md_busy
  );

  modport slave (
    input  id_rs_num, id_rt_num, id_uses_rs, id_uses_rt,
           ex_mem_read, ex_reg_addr, ex_md_op,
    output pc_stall, if_id_stall, id_ex_stall, id_ex_flush,
           ex_mem_bubble, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_timer.sv
// Loadable down-counter that tracks remaining stalled cycles of a mul/div.
// Counts down by itself and parks at zero; zero flags the release cycle.
module hazard_md_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q;

  // Load takes priority over the free-running decrement; stop at zero.
  always_ff @(posedge clk) begin
    if (rst)                cnt_q <= '0;
    else if (load)          cnt_q <= load_val;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / mul-div hazard and stall controller for the 5-stage core.
// Stall/flush outputs are combinational from inputs, state and counter.
// Optional macro HAZ_PERF_CNT_EN adds three 32-bit performance counters.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MD_LAT     = MD_LAT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  hazard_stall_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]        perf_loaduse_cnt,
  output logic [31:0]        perf_md_stall_cnt,
  output logic [31:0]        perf_md_ops_cnt
`endif
);
  hz_state_e        state_q, state_d;
  logic             load_use;
  logic             md_load;
  logic             md_zero;
  logic [CNT_W-1:0] md_cnt;
  logic             pc_stall, if_id_stall, id_ex_stall, id_ex_flush;
  logic             ex_mem_bubble, md_busy;

  // Loads into r0 are harmless: r0 always reads as zero.
  assign load_use = hz.ex_mem_read && (hz.ex_reg_addr != '0) &&
                    ((hz.id_uses_rs && (hz.id_rs_num == hz.ex_reg_addr)) ||
                     (hz.id_uses_rt && (hz.id_rt_num == hz.ex_reg_addr)));

  hazard_md_timer #(.CNT_W(CNT_W)) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (CNT_W'(MD_LAT - 2)),
    .cnt      (md_cnt),
    .zero     (md_zero)
  );

  // Next-state and stall decode; mul/div sequencing outranks load-use.
  always_comb begin
    state_d       = state_q;
    md_load       = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_busy       = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (hz.ex_md_op) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          md_load       = 1'b1;
          state_d       = HZ_MD_BUSY;
        end else if (load_use) begin
          // Load moves on to MEM while ID is held: one bubble clears it.
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      HZ_MD_BUSY: begin
        // ex_md_op stays high while ID/EX is held, so it is ignored here.
        md_busy = 1'b1;
        if (!md_zero) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
        end else begin
          state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= HZ_RUN;
    else     state_q <= state_d;
  end

  assign hz.pc_stall      = pc_stall;
  assign hz.if_id_stall   = if_id_stall;
  assign hz.id_ex_stall   = id_ex_stall;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_bubble = ex_mem_bubble;
  assign hz.md_busy       = md_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] lu_cnt_q, mds_cnt_q, mdo_cnt_q;

  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mds_cnt_q <= '0;
      mdo_cnt_q <= '0;
    end else begin
      if (state_q == HZ_RUN && load_use && !hz.ex_md_op) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (id_ex_stall)                                    mds_cnt_q <= mds_cnt_q + 32'd1;
      if (state_q == HZ_RUN && hz.ex_md_op)               mdo_cnt_q <= mdo_cnt_q + 32'd1;
    end
  end

  assign perf_loaduse_cnt  = lu_cnt_q;
  assign perf_md_stall_cnt = mds_cnt_q;
  assign perf_md_ops_cnt   = mdo_cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^md_cnt;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes expected output
// vectors {pc,if_id,id_ex_stall,flush,bubble,md_busy}; a monitor pops and
// compares at every falling edge.
module tb_hazard_stall_ctrl;
  localparam int MD_LAT = 8;

  localparam logic [5:0] ZERO = 6'b000000;
  localparam logic [5:0] LU   = 6'b110100;
  localparam logic [5:0] MDS  = 6'b111010; // RUN cycle that starts a mul/div
  localparam logic [5:0] BSY  = 6'b111011; // stalled busy cycle
  localparam logic [5:0] REL  = 6'b000001; // release cycle

  typedef struct {
    logic [5:0] v;
    string      nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) hz ();

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] p_lu, p_mds, p_mdo;
  hazard_stall_ctrl #(.REG_ADDR_W(5), .MD_LAT(MD_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .hz(hz.slave),
    .perf_loaduse_cnt(p_lu), .perf_md_stall_cnt(p_mds), .perf_md_ops_cnt(p_mdo));
`else
  hazard_stall_ctrl #(.REG_ADDR_W(5), .MD_LAT(MD_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .hz(hz.slave));
`endif

  always #5 clk = ~clk;

  // Monitor: one output vector per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall,
               hz.id_ex_flush, hz.ex_mem_bubble, hz.md_busy};
        checks++;
        if (act !== e.v) $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
        else passed++;
      end
    end
  end

  task automatic drv(input logic r, input logic md, input logic rd,
                     input logic [4:0] ea, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic [5:0] ev, input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst            = r;
    hz.ex_md_op    = md;
    hz.ex_mem_read = rd;
    hz.ex_reg_addr = ea;
    hz.id_rs_num   = rs;
    hz.id_rt_num   = rt;
    hz.id_uses_rs  = urs;
    hz.id_uses_rt  = urt;
    e.v = ev; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input string nm);
    drv(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ZERO, nm);
  endtask

  // Full mul/div with ex_md_op held until release.
  task automatic md_op(input string nm);
    drv(0, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, MDS, {nm, "_start"});
    for (int i = 0; i < MD_LAT - 2; i++)
      drv(0, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, BSY, {nm, "_busy"});
    drv(0, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, REL, {nm, "_release"});
  endtask

  initial begin
    hz.ex_md_op = 0; hz.ex_mem_read = 0; hz.ex_reg_addr = '0;
    hz.id_rs_num = '0; hz.id_rt_num = '0; hz.id_uses_rs = 0; hz.id_uses_rt = 0;
    repeat (2) @(posedge clk);

    drv(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ZERO, "reset_idle");
    drv(1, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, LU,   "reset_lu_comb");
    idle("post_reset");
    // load-use on rs: one bubble, then the load has moved on
    drv(0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, LU,   "lu_rs");
    drv(0, 0, 0, 5'd8, 5'd8, 5'd0, 1, 0, ZERO, "lu_cleared");
    drv(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, ZERO, "lu_r0");
    drv(0, 0, 1, 5'd8, 5'd1, 5'd8, 1, 0, ZERO, "lu_rt_unused");
    drv(0, 0, 1, 5'd8, 5'd1, 5'd8, 1, 1, LU,   "lu_rt");
    drv(0, 0, 1, 5'd9, 5'd8, 5'd8, 1, 1, ZERO, "lu_no_match");
    // mul/div with simultaneous load-use in the start cycle: mul/div wins
    drv(0, 1, 1, 5'd8, 5'd8, 5'd0, 1, 0, MDS, "md_over_lu");
    for (int i = 0; i < MD_LAT - 2; i++)
      drv(0, 1, 0, 5'd8, 5'd8, 5'd0, 1, 0, BSY, "md1_busy");
    drv(0, 1, 0, 5'd8, 5'd8, 5'd0, 1, 0, REL, "md1_release");
    // back-to-back: next RUN cycle restarts, then reset on 3rd busy cycle
    drv(0, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, MDS, "md2_start");
    drv(0, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, BSY, "md2_busy1");
    drv(0, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, BSY, "md2_busy2");
    drv(1, 1, 0, 5'd3, 5'd1, 5'd2, 1, 1, BSY, "md2_busy3_rst");
    idle("after_mid_rst");
    md_op("md3");
    idle("md3_done");

`ifdef HAZ_PERF_CNT_EN
    drv(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ZERO, "perf_rst");
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0, LU, "perf_lu");
      idle("perf_gap");
    end
    md_op("perf_md_a");
    md_op("perf_md_b");
    idle("perf_end");
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (q.size() != 0) $display("FAIL drain: %0d entries left, expected 0", q.size());
    else passed++;

`ifdef HAZ_PERF_CNT_EN
    checks++; if (p_lu  !== 32'd3) $display("FAIL perf_loaduse: got %0d expected 3", p_lu); else passed++;
    checks++; if (p_mdo !== 32'd2) $display("FAIL perf_md_ops: got %0d expected 2", p_mdo); else passed++;
    checks++;
    if (p_mds !== 32'(2 * (MD_LAT - 1))) $display("FAIL perf_md_stall: got %0d expected %0d", p_mds, 2 * (MD_LAT - 1));
    else passed++;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
